rdata_aligner: RTL and testbench

//  Read-side counterpart of the DMA write aligner. Serves sequential DATA_W-word dbus reads from any byte

---
 rtl/rdata_aligner_pkg.sv | 36 +++
 rtl/rdata_aligner_funnel.sv | 41 ++++
 rtl/rdata_aligner.sv | 243 ++++++++++++++++++++++++
 tb/tb_rdata_aligner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rdata_aligner_pkg.sv
// rtl/rdata_aligner_pkg.sv - shared DMA widths, read-aligner state encoding and constants
//
// Holds the DMA burst-length width and the read-aligner state encoding used by
// rdata_aligner. The macros sit next to the write-aligner state macros so both
// aligners draw on one set of DMA-side definitions.

`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

`ifndef RALGN_STATES_W
`define RALGN_STATES_W 3
`define RALGN_IDLE     3'd0
`define RALGN_CONFIG   3'd1
`define RALGN_PRIME    3'd2
`define RALGN_STREAM   3'd3
`define RALGN_FLUSH    3'd4
`define RALGN_DONE     3'd5
`endif

package rdata_aligner_pkg;

  // Burst length field width and the longest burst it can describe (in beats).
  localparam int unsigned LEN_W      = `AXI_LEN_W;
  localparam int unsigned MAX_BURST  = 1 << LEN_W;

  typedef enum logic [`RALGN_STATES_W-1:0] {
    S_IDLE   = `RALGN_IDLE,
    S_CONFIG = `RALGN_CONFIG,
    S_PRIME  = `RALGN_PRIME,
    S_STREAM = `RALGN_STREAM,
    S_FLUSH  = `RALGN_FLUSH,
    S_DONE   = `RALGN_DONE
  } ralgn_state_e;

endpackage

// File: rtl/rdata_aligner_funnel.sv
// rtl/rdata_aligner_funnel.sv - byte funnel shifter with end-of-range byte mask
//
// Ports:
//   hi_i        newer (higher-address) beat
//   lo_i        older (lower-address) beat
//   off_i       byte offset of the requested start within a beat
//   mask_en_i   1 when the produced word is the last one of the range
//   last_lane_i highest byte lane still inside the range (used when mask_en_i)
//   word_o      unaligned word, lane k = byte at (request address + k)

module rdata_funnel #(
  parameter int DATA_W = 32,
  localparam int B        = DATA_W / 8,
  localparam int OFFSET_W = $clog2(B)
) (
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic [OFFSET_W-1:0] off_i,
  input  logic                mask_en_i,
  input  logic [OFFSET_W-1:0] last_lane_i,
  output logic [DATA_W-1:0]   word_o
);

  always_comb begin
    // An aligned stream passes the new beat straight through; otherwise the
    // word straddles the held beat and the new one.
    if (off_i == '0) begin
      word_o = hi_i;
    end else begin
      word_o = DATA_W'({hi_i, lo_i} >> (8 * off_i));
    end
    if (mask_en_i) begin
      for (int k = 0; k < B; k++) begin
        if (k > int'(last_lane_i)) begin
          word_o[8*k +: 8] = 8'h00;
        end
      end
    end
  end

endmodule

// File: rtl/rdata_aligner.sv
// rtl/rdata_aligner.sv - unaligned dbus read server fed by aligned DMA read bursts
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   clear            synchronous abort back to IDLE
//   run              enable; dbus requests are only taken while high
//   endAddr          last byte address of the range (inclusive)
//   dbus_valid/addr  read request from the accelerator, held until dbus_ready
//   dbus_rdata/ready unaligned word and its one-cycle retire pulse
//   dma_r_valid      a beat may be accepted this cycle
//   dma_r_addr/len   aligned burst base address and beats-1
//   dma_r_rdata      beat data, taken when dma_r_valid && dma_r_ready

`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module rdata_aligner
  import rdata_aligner_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run,
  input  logic [ADDR_W-1:0]     endAddr,
  input  logic                  dbus_valid,
  input  logic [ADDR_W-1:0]     dbus_addr,
  output logic [DATA_W-1:0]     dbus_rdata,
  output logic                  dbus_ready,
  output logic                  dma_r_valid,
  output logic [ADDR_W-1:0]     dma_r_addr,
  output logic [`AXI_LEN_W-1:0] dma_r_len,
  input  logic [DATA_W-1:0]     dma_r_rdata,
  input  logic                  dma_r_ready
);

  localparam int B        = DATA_W / 8;
  localparam int OFFSET_W = $clog2(B);
  localparam int REM_W    = LEN_W + 1;

  localparam logic [ADDR_W-1:0] MAX_BEATS = ADDR_W'(MAX_BURST);

  // Length field for a burst that still has 'beats' beats to go.
  function automatic logic [LEN_W-1:0] len_for(input logic [ADDR_W-1:0] beats);
    logic [ADDR_W-1:0] n;
    n = (beats > MAX_BEATS) ? MAX_BEATS : beats;
    return LEN_W'(n - ADDR_W'(1));
  endfunction

  ralgn_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     start_q, start_d;
  logic [ADDR_W-1:0]     end_q, end_d;
  logic [OFFSET_W-1:0]   off_q, off_d;
  logic [ADDR_W-1:0]     beats_left_q, beats_left_d;
  logic [ADDR_W-1:0]     words_left_q, words_left_d;
  logic [ADDR_W-1:0]     burst_addr_q, burst_addr_d;
  logic [LEN_W-1:0]      burst_len_q, burst_len_d;
  logic [REM_W-1:0]      burst_rem_q, burst_rem_d;
  logic [ADDR_W-1:0]     word_addr_q, word_addr_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic                  req;
  logic                  beat_acc;
  logic                  retire;
  logic                  last_word;
  logic [OFFSET_W-1:0]   last_lane;
  logic [DATA_W-1:0]     funnel_hi;
  logic [DATA_W-1:0]     funnel_word;
  logic [ADDR_W-1:0]     cfg_beats;
  logic [LEN_W-1:0]      cfg_len;
  logic [LEN_W-1:0]      next_len;

  assign req       = run & dbus_valid;
  // Beats are only taken while the output register is free, so at most one
  // word is ever waiting on the dbus side and no beat can be lost.
  assign dma_r_valid = ((state_q == S_PRIME) || (state_q == S_STREAM)) &&
                       (beats_left_q != '0) && !out_valid_q;
  assign beat_acc  = dma_r_valid & dma_r_ready;
  assign retire    = out_valid_q & req;
  assign last_word = (words_left_q == ADDR_W'(1));
  assign last_lane = OFFSET_W'(end_q - word_addr_q);
  // FLUSH has no new beat: the upper half of the funnel is zero.
  assign funnel_hi = (state_q == S_FLUSH) ? '0 : dma_r_rdata;

  assign dbus_ready = retire;
  assign dbus_rdata = out_data_q;
  assign dma_r_addr = burst_addr_q;
  assign dma_r_len  = burst_len_q;

  rdata_funnel #(
    .DATA_W (DATA_W)
  ) u_funnel (
    .hi_i        (funnel_hi),
    .lo_i        (hold_q),
    .off_i       (off_q),
    .mask_en_i   (last_word),
    .last_lane_i (last_lane),
    .word_o      (funnel_word)
  );

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    end_d        = end_q;
    off_d        = off_q;
    beats_left_d = beats_left_q;
    words_left_d = words_left_q;
    burst_addr_d = burst_addr_q;
    burst_len_d  = burst_len_q;
    burst_rem_d  = burst_rem_q;
    word_addr_d  = word_addr_q;
    hold_d       = hold_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;

    cfg_beats = ((end_q >> OFFSET_W) - (start_q >> OFFSET_W)) + ADDR_W'(1);
    cfg_len   = len_for(cfg_beats);
    next_len  = len_for(beats_left_q - ADDR_W'(1));

    // Burst bookkeeping: on the last beat of a burst, the next burst is
    // loaded immediately so the DMA side sees no idle cycle between them.
    if (beat_acc) begin
      beats_left_d = beats_left_q - ADDR_W'(1);
      hold_d       = dma_r_rdata;
      if (burst_rem_q == REM_W'(1)) begin
        if (beats_left_q != ADDR_W'(1)) begin
          burst_addr_d = burst_addr_q + ((ADDR_W'(burst_len_q) + ADDR_W'(1)) << OFFSET_W);
          burst_len_d  = next_len;
          burst_rem_d  = REM_W'(next_len) + REM_W'(1);
        end else begin
          burst_rem_d  = '0;
        end
      end else begin
        burst_rem_d = burst_rem_q - REM_W'(1);
      end
    end

    if (retire) begin
      out_valid_d  = 1'b0;
      words_left_d = words_left_q - ADDR_W'(1);
      word_addr_d  = word_addr_q + ADDR_W'(B);
    end

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          start_d = dbus_addr;
          end_d   = endAddr;
          state_d = S_CONFIG;
        end
      end

      S_CONFIG: begin
        off_d        = start_q[OFFSET_W-1:0];
        beats_left_d = cfg_beats;
        words_left_d = ((end_q - start_q) >> OFFSET_W) + ADDR_W'(1);
        burst_addr_d = start_q & ~ADDR_W'(B - 1);
        burst_len_d  = cfg_len;
        burst_rem_d  = REM_W'(cfg_len) + REM_W'(1);
        word_addr_d  = start_q;
        hold_d       = '0;
        out_valid_d  = 1'b0;
        state_d      = (start_q[OFFSET_W-1:0] != '0) ? S_PRIME : S_STREAM;
      end

      // Unaligned start: the first beat only fills the hold register.
      S_PRIME: begin
        if (beat_acc) begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (beat_acc) begin
          out_data_d  = funnel_word;
          out_valid_d = 1'b1;
        end
        if (retire && last_word) begin
          state_d = S_DONE;
        end else if (!out_valid_q && (beats_left_q == '0) && last_word) begin
          // The tail bytes of the range are already in the hold register.
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (!out_valid_q) begin
          out_data_d  = funnel_word;
          out_valid_d = 1'b1;
        end
        if (retire && last_word) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q      <= S_IDLE;
      start_q      <= '0;
      end_q        <= '0;
      off_q        <= '0;
      beats_left_q <= '0;
      words_left_q <= '0;
      burst_addr_q <= '0;
      burst_len_q  <= '0;
      burst_rem_q  <= '0;
      word_addr_q  <= '0;
      hold_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      end_q        <= end_d;
      off_q        <= off_d;
      beats_left_q <= beats_left_d;
      words_left_q <= words_left_d;
      burst_addr_q <= burst_addr_d;
      burst_len_q  <= burst_len_d;
      burst_rem_q  <= burst_rem_d;
      word_addr_q  <= word_addr_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_rdata_aligner.sv
// tb/tb_rdata_aligner.sv - directed self-checking bench for rdata_aligner

module tb_rdata_aligner;

  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        run;
  logic [31:0] endAddr;
  logic        dbus_valid;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_rdata;
  logic        dbus_ready;
  logic        dma_r_valid;
  logic [31:0] dma_r_addr;
  logic [7:0]  dma_r_len;
  logic [31:0] dma_r_rdata = '0;
  logic        dma_r_ready;

  int checks = 0;
  int errors = 0;

  // DMA model state (written only by the model process)
  int          beat_idx = 0;
  int          beats_seen = 0;
  logic [31:0] burst_log_addr[$];
  int          burst_log_len[$];

  // Per-run bases (written only by the main thread)
  int          beat_base = 0;
  int          log_base = 0;

  always #5 clk = ~clk;

  rdata_aligner #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .run         (run),
    .endAddr     (endAddr),
    .dbus_valid  (dbus_valid),
    .dbus_addr   (dbus_addr),
    .dbus_rdata  (dbus_rdata),
    .dbus_ready  (dbus_ready),
    .dma_r_valid (dma_r_valid),
    .dma_r_addr  (dma_r_addr),
    .dma_r_len   (dma_r_len),
    .dma_r_rdata (dma_r_rdata),
    .dma_r_ready (dma_r_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // DMA read port model: byte at address a reads as a[7:0]. Decides at the
  // negedge whether the coming posedge is a handshake and presents that beat.
  always @(negedge clk) begin : dma_model
    logic [31:0] a;
    if (rst || clear) begin
      beat_idx = 0;
    end else if (dma_r_valid && dma_r_ready) begin
      if (beat_idx == 0) begin
        burst_log_addr.push_back(dma_r_addr);
        burst_log_len.push_back(int'(dma_r_len));
      end
      a = dma_r_addr + 32'(beat_idx * 4);
      dma_r_rdata = {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
      beats_seen++;
      if (beat_idx == int'(dma_r_len)) beat_idx = 0;
      else beat_idx++;
    end
  end

  task automatic run_words(input string tag, input logic [31:0] start, input logic [31:0] last,
                           input int nwords, input word_q_t exp_q,
                           input int stall_after, input int stall_len);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    beat_base = beats_seen;
    log_base  = burst_log_addr.size();
    @(posedge clk); #1;
    endAddr    = last;
    dbus_addr  = start;
    dbus_valid = 1'b1;
    while (got < nwords && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (dbus_ready) begin
        check_eq($sformatf("%s word%0d", tag, got), dbus_rdata, exp_q[got]);
        got++;
        @(posedge clk); #1;
        dbus_addr = dbus_addr + 32'd4;
        if (got == nwords) begin
          dbus_valid = 1'b0;
        end else if (got == stall_after) begin
          dbus_valid = 1'b0;
          for (int i = 0; i < stall_len; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s stall%0d dbus_ready", tag, i), 32'(dbus_ready), 32'd0);
            if (i >= 1)
              check_eq($sformatf("%s stall%0d dma_r_valid", tag, i), 32'(dma_r_valid), 32'd0);
            @(posedge clk); #1;
          end
          dbus_valid = 1'b1;
        end
      end
    end
    check_eq($sformatf("%s word count", tag), 32'(got), 32'(nwords));
  endtask

  task automatic check_bursts(input string tag, input int nbeats, input int nbursts,
                              input logic [31:0] a0, input int l0,
                              input logic [31:0] a1, input int l1);
    repeat (4) @(posedge clk);
    #1;
    check_eq($sformatf("%s beats", tag), 32'(beats_seen - beat_base), 32'(nbeats));
    check_eq($sformatf("%s bursts", tag), 32'(burst_log_addr.size() - log_base), 32'(nbursts));
    if (burst_log_addr.size() > log_base) begin
      check_eq($sformatf("%s burst0 addr", tag), burst_log_addr[log_base], a0);
      check_eq($sformatf("%s burst0 len", tag), 32'(burst_log_len[log_base]), 32'(l0));
    end
    if (nbursts > 1 && burst_log_addr.size() > log_base + 1) begin
      check_eq($sformatf("%s burst1 addr", tag), burst_log_addr[log_base+1], a1);
      check_eq($sformatf("%s burst1 len", tag), 32'(burst_log_len[log_base+1]), 32'(l1));
    end
    check_eq($sformatf("%s idle dma_r_valid", tag), 32'(dma_r_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq($sformatf("%s dbus_ready", tag), 32'(dbus_ready), 32'd0);
    check_eq($sformatf("%s dbus_rdata", tag), dbus_rdata, 32'd0);
    check_eq($sformatf("%s dma_r_valid", tag), 32'(dma_r_valid), 32'd0);
    check_eq($sformatf("%s dma_r_addr", tag), dma_r_addr, 32'd0);
    check_eq($sformatf("%s dma_r_len", tag), 32'(dma_r_len), 32'd0);
  endtask

  initial begin : main
    word_q_t     e;
    word_q_t     e4;
    logic [7:0]  b;

    rst         = 1'b1;
    clear       = 1'b0;
    run         = 1'b0;
    endAddr     = '0;
    dbus_valid  = 1'b0;
    dbus_addr   = '0;
    dma_r_ready = 1'b1;

    for (int i = 0; i < 512; i++) begin
      b = 8'(4 * i);
      e4.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // run low: requests must be ignored
    @(posedge clk); #1;
    dbus_valid = 1'b1;
    dbus_addr  = 32'h100;
    endAddr    = 32'h10F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("run0 dma_r_valid", 32'(dma_r_valid), 32'd0);
      check_eq("run0 dbus_ready", 32'(dbus_ready), 32'd0);
    end
    @(posedge clk); #1;
    dbus_valid = 1'b0;
    run        = 1'b1;

    // 1: aligned, one burst of 4
    e = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    run_words("c1", 32'h100, 32'h10F, 4, e, 0, 0);
    check_bursts("c1", 4, 1, 32'h100, 3, 32'h0, 0);

    // 2: offset 1, three beats, two words
    e = '{32'h04030201, 32'h08070605};
    run_words("c2", 32'h101, 32'h108, 2, e, 0, 0);
    check_bursts("c2", 3, 1, 32'h100, 2, 32'h0, 0);

    // 3: single byte at offset 3: PRIME then FLUSH
    e = '{32'h00000003};
    run_words("c3", 32'h103, 32'h103, 1, e, 0, 0);
    check_bursts("c3", 1, 1, 32'h100, 0, 32'h0, 0);

    // flushed word with end mask: offset 2, end inside the hold beat
    e = '{32'h05040302, 32'h00000006};
    run_words("cflush", 32'h102, 32'h106, 2, e, 0, 0);
    check_bursts("cflush", 2, 1, 32'h100, 1, 32'h0, 0);

    // aligned start, end mask on last word
    e = '{32'h03020100, 32'h00000504};
    run_words("cmask", 32'h200, 32'h205, 2, e, 0, 0);
    check_bursts("cmask", 2, 1, 32'h200, 1, 32'h0, 0);

    // 4: two back-to-back maximal bursts
    run_words("c4", 32'h000, 32'h7FF, 512, e4, 0, 0);
    check_bursts("c4", 512, 2, 32'h000, 255, 32'h400, 255);

    // 5: case 2 with a 5-cycle dbus stall after word0
    e = '{32'h04030201, 32'h08070605};
    run_words("c5", 32'h101, 32'h108, 2, e, 1, 5);
    check_bursts("c5", 3, 1, 32'h100, 2, 32'h0, 0);

    // 6: clear mid-burst, then rst mid-burst, then a fresh aligned run
    run_words("c6a", 32'h000, 32'h7FF, 50, e4, 0, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check_all_zero("clear");
    repeat (2) @(posedge clk);

    run_words("c6b", 32'h000, 32'h7FF, 30, e4, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst mid");
    repeat (2) @(posedge clk);

    e = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    run_words("c6c", 32'h100, 32'h10F, 4, e, 0, 0);
    check_bursts("c6c", 4, 1, 32'h100, 3, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
